// File: rtl/sfx_sequencer.sv
// Sound-effect scheduler: fixed-priority, preemptive arbitration of game sound
// requests, each played as a timed ROM script driving note select and audio enable.
module sfx_sequencer #(
  parameter int TICK_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bump,
  input  logic       snakeEatCherry,
  input  logic       game_start,
  input  logic       sfx_mute,
  output logic [2:0] note,
  output logic       snd_en,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t        state;
  logic [2:0]    req_p0;
  logic [2:0]    pending;
  logic [2:0]    req_edge;
  logic [2:0]    grant_mask;
  logic [1:0]    grant_id;
  logic [1:0]    low_id;
  logic [1:0]    step_idx;
  logic [PW-1:0] presc;
  logic [5:0]    tick;
  logic          gate;
  logic          gate_nxt;
  logic          step_end;
  logic          last_step;
  logic          preempt;

  // Script ROM: every step of a given script has the same length.
  function automatic logic [5:0] step_ticks(input logic [1:0] id);
    case (id)
      2'd1:    return 6'd40;
      2'd2:    return 6'd10;
      2'd3:    return 6'd20;
      default: return 6'd1;
    endcase
  endfunction

  function automatic logic [2:0] step_note(input logic [1:0] id, input logic [1:0] idx);
    case (id)
      2'd2:    return {1'b0, idx};
      2'd3:    return (idx == 2'd0) ? 3'd0 : 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic step_gate(input logic [1:0] id, input logic [1:0] idx);
    return !((id == 2'd1) && (idx == 2'd1));
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] id);
    case (id)
      2'd1:    return 2'd2;
      2'd2:    return 2'd3;
      2'd3:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] lowest(input logic [2:0] p);
    if (p[0]) return 2'd1;
    if (p[1]) return 2'd2;
    if (p[2]) return 2'd3;
    return 2'd0;
  endfunction

  always_comb begin
    req_edge  = {game_start, snakeEatCherry, bump} & ~req_p0;
    low_id    = lowest(pending);
    case (grant_id)
      2'd1:    grant_mask = 3'b001;
      2'd2:    grant_mask = 3'b010;
      2'd3:    grant_mask = 3'b100;
      default: grant_mask = 3'b000;
    endcase
    step_end  = (presc == PRESC_MAX) && (tick == step_ticks(active_id) - 6'd1);
    last_step = (step_idx == last_idx(active_id));
    preempt   = (state == PLAY) && (pending != 3'b000) && (low_id <= active_id);
    gate_nxt  = gate;
    if (state == LOAD)
      gate_nxt = step_gate(grant_id, 2'd0);
    else if ((state == PLAY) && !preempt && step_end)
      gate_nxt = last_step ? 1'b0 : step_gate(active_id, step_idx + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_p0    <= 3'b000;
      pending   <= 3'b000;
      grant_id  <= 2'd0;
      step_idx  <= 2'd0;
      presc     <= '0;
      tick      <= 6'd0;
      gate      <= 1'b0;
      note      <= 3'd4;
      snd_en    <= 1'b0;
      busy      <= 1'b0;
      active_id <= 2'd0;
      done      <= 1'b0;
    end else begin
      req_p0 <= {game_start, snakeEatCherry, bump};
      done   <= 1'b0;
      gate   <= gate_nxt;
      snd_en <= gate_nxt & ~sfx_mute;
      // A new edge on the source being loaded re-arms it rather than being lost.
      if (state == LOAD)
        pending <= (pending & ~grant_mask) | req_edge;
      else
        pending <= pending | req_edge;
      case (state)
        IDLE: begin
          if (pending != 3'b000) begin
            grant_id <= low_id;
            state    <= LOAD;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          active_id <= grant_id;
          step_idx  <= 2'd0;
          presc     <= '0;
          tick      <= 6'd0;
          note      <= step_note(grant_id, 2'd0);
          state     <= PLAY;
        end
        PLAY: begin
          if (preempt) begin
            grant_id <= low_id;
            state    <= LOAD;
          end else if (step_end) begin
            presc <= '0;
            tick  <= 6'd0;
            if (last_step) begin
              state     <= IDLE;
              note      <= 3'd4;
              active_id <= 2'd0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              step_idx <= step_idx + 2'd1;
              note     <= step_note(active_id, step_idx + 2'd1);
            end
          end else if (presc == PRESC_MAX) begin
            presc <= '0;
            tick  <= tick + 6'd1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect scheduler for the audio PWM path. It arbitrates game sound requests (bump, cherry eaten, game start) under fixed priority with preemption. It then plays each granted event as a short script of timed steps, driving the note select and the audio enable (AUD_SD) of the tone generator. It replaces ad-hoc per-event delay counters with one sequenced, testable owner of the speaker.

## Interface
- TICK_CYCLES, 500000: clk cycles per script tick (5 ms at 100 MHz); legal range ≥2.
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- bump  in  1  request level/pulse, ID 1, highest priority.
- snakeEatCherry  in  1  request level/pulse, ID 2.
- game_start  in  1  request level/pulse, ID 3, lowest priority.
- sfx_mute  in  1  forces snd_en low; sequencing continues.
- note  out  3  note select to the tone generator: 0–3 arpeggio notes, 4 middle C.
- snd_en  out  1  audio enable, drives AUD_SD.
- busy  out  1  high while an event is loading or playing.
- active_id  out  2  ID of the event being played; 0 when idle.
- done  out  1  one-cycle pulse when an event completes naturally.

## Operation
- **Request capture.** Each request is registered and rising-edge detected. An edge sets that source's pending bit at the same clock edge. Holding a request high does not retrigger.
- **Scripts** (fixed ROM, steps given as {note, gate, ticks}):
  - ID1 bump: {4, on, 40}, {4, off, 40}, {4, on, 40}.
  - ID2 eat: {0, on, 10}, {1, on, 10}, {2, on, 10}, {3, on, 10}.
  - ID3 start: {0, on, 20}, {3, on, 20}.
- **FSM states: IDLE, LOAD, PLAY.**
  - IDLE: if any pending bit is set, grant the lowest pending ID and go to LOAD.
  - LOAD (1 cycle): clear the granted pending bit; set active_id; load step 0; clear the prescaler and tick counter; go to PLAY.
  - PLAY: the prescaler counts 0..TICK_CYCLES-1. The tick counter increments when the prescaler wraps.
    - A step ends in the cycle where the tick counter equals step_ticks-1 and the prescaler equals TICK_CYCLES-1.
    - If this is not the last step, load the next step in the same cycle, with no gap.
    - If it is the last step, go to IDLE, set note=4, snd_en=0, active_id=0, and pulse done.
- **Preemption, evaluated every PLAY cycle with priority over step end:**
  - A pending ID lower than or equal to active_id causes LOAD of that ID. Equal ID restarts the script. The preempted event is dropped and done is not pulsed.
  - A pending ID greater than active_id stays pending and is served after completion.
- **Outputs** are registered.
  - snd_en = step gate AND NOT sfx_mute, registered.
  - note holds the step note, including during gate-off steps.
  - busy = (state ≠ IDLE).
- **Reset** (any state): state=IDLE, pending=0, request registers=0, prescaler=0, tick=0, note=4, snd_en=0, busy=0, active_id=0, done=0.
- **Edges during reset:** a request edge in the same cycle as rst is discarded.
- **Width:** the tick counter is 6 bits (max 40 ticks). The prescaler is $clog2(TICK_CYCLES) bits.

## Timing
- **Request latency.** Request high first sampled at edge k sets pending after k. The state is LOAD after k+1. note, snd_en and active_id are valid after k+2.
- **Step length** is exactly step_ticks × TICK_CYCLES cycles. Consecutive steps are contiguous.
- **Event length:** bump 120, eat 40, start 40 ticks, plus 1 LOAD cycle.
- **Completion.** done is high for exactly the one cycle after the final step ends, concurrent with snd_en=0 and busy=0.
- **Back-to-back events.** A pending event is served with IDLE→LOAD, so there is a 2-cycle gap of snd_en=0 between events.
- **Simultaneous edges** set multiple pending bits. The lowest ID is granted first, and the others are served in ID order afterwards.

## Test plan
All scenarios use TICK_CYCLES=4 and request edge at cycle 0.
- **Bump alone.** Stimulus: bump pulse at cycle 0. Required response:
  - snd_en=1 in cycles 2–161, 0 in cycles 162–321, 1 in cycles 322–481.
  - done=1 at cycle 482, busy=0 from cycle 482, note=4 throughout.
- **Eat arpeggio.** Stimulus: snakeEatCherry pulse at cycle 0. Required response:
  - note=0, 1, 2, 3 in 40-cycle blocks starting at cycle 2.
  - snd_en continuously 1 over cycles 2–161.
  - done at cycle 162.
- **Preemption.** Stimulus: eat at cycle 0, bump at cycle 50. Required response:
  - active_id switches 2→1 at cycle 52, bump script starts at cycle 52.
  - No done pulse for eat; exactly one done pulse at cycle 532.
- **Queued lower priority.** Stimulus: bump at cycle 0, game_start at cycle 10. Required response:
  - Start is held pending; done at cycle 482.
  - active_id=3 at cycle 484; note=0, then note=3 at 80 cycles each.
- **Same-ID restart, mute, held level.** Stimulus and required response:
  - Eat at cycle 0 and again at cycle 100: the script restarts at cycle 102 with note=0 and done at cycle 262.
  - sfx_mute high: snd_en stays 0 while note still steps.
  - Holding bump high for 1000 cycles yields only one event.
- **Reset mid-event.** Stimulus: rst at cycle 200 of a bump. Required response:
  - At cycle 201: note=4, snd_en=0, busy=0, active_id=0, no pending.
  - A bump edge at cycle 200 is ignored.
